// File: rtl/pbl3_pkg.sv
// Shared types and helpers for the arbitrating multiplexer.
// onehot_to_idx handles up to ARB_MAX_IN requesters.
package pbl3_pkg;

    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

    localparam int ARB_MAX_IN = 32;

    function automatic int onehot_to_idx(input logic [ARB_MAX_IN-1:0] i_onehot);
        int idx;
        idx = 0;
        for (int k = 0; k < ARB_MAX_IN; k++) begin
            if (i_onehot[k]) idx = k;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority grant logic.
// Owns the rotating priority pointer, which advances only when the grant is consumed.
module rr_arbiter
    import pbl3_pkg::*;
#(
    parameter int        P_NUM_IN = 4,
    parameter arb_mode_e P_MODE   = ARB_RR,
    localparam int       SEL_W    = (P_NUM_IN > 1) ? $clog2(P_NUM_IN) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [P_NUM_IN-1:0] i_req,
    input  logic                i_advance,
    output logic [P_NUM_IN-1:0] o_grant,
    output logic [SEL_W-1:0]    o_grant_idx
);

    logic [SEL_W-1:0]    r_ptr;
    logic [P_NUM_IN-1:0] w_grant;
    int                  w_best;
    int                  w_dist;

    // Each requester's priority is its distance from the pointer; smallest distance wins.
    always_comb begin
        w_grant = '0;
        w_best  = P_NUM_IN;
        w_dist  = 0;
        for (int k = 0; k < P_NUM_IN; k++) begin
            w_dist = (P_MODE == ARB_RR) ? (k - int'(r_ptr)) : k;
            if (w_dist < 0) w_dist = w_dist + P_NUM_IN;
            if (i_req[k] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_grant    = '0;
                w_grant[k] = 1'b1;
            end
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = SEL_W'(onehot_to_idx(ARB_MAX_IN'(w_grant)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if ((P_MODE == ARB_RR) && i_advance) begin
            r_ptr <= (int'(o_grant_idx) == P_NUM_IN - 1) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input arbitrating multiplexer with a single registered output stage.
// Handshake: a word moves when valid & ready are both high at a rising edge; o_ready is one-hot or zero.
module rr_arb_mux
    import pbl3_pkg::*;
#(
    parameter int        P_WIDTH  = 32,
    parameter int        P_NUM_IN = 4,
    parameter arb_mode_e P_MODE   = ARB_RR,
    localparam int       SEL_W    = (P_NUM_IN > 1) ? $clog2(P_NUM_IN) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [P_NUM_IN-1:0]          i_valid,
    output logic [P_NUM_IN-1:0]          o_ready,
    input  logic [P_NUM_IN*P_WIDTH-1:0]  i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [P_WIDTH-1:0]           o_data,
    output logic [SEL_W-1:0]             o_sel
);

    logic [P_NUM_IN-1:0] w_grant;
    logic [SEL_W-1:0]    w_grant_idx;
    logic                w_can_load;
    logic                w_in_xfer;
    logic [P_WIDTH-1:0]  w_sel_data;

    logic                r_valid;
    logic [P_WIDTH-1:0]  r_data;
    logic [SEL_W-1:0]    r_sel;

    rr_arbiter #(
        .P_NUM_IN (P_NUM_IN),
        .P_MODE   (P_MODE)
    ) u_arbiter (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_valid),
        .i_advance   (w_in_xfer),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Reset is folded in so no channel sees an accept while the stage is held in reset.
    assign w_can_load = i_rst_n && (!r_valid || i_ready);
    assign o_ready    = w_can_load ? w_grant : '0;
    assign w_in_xfer  = |(i_valid & o_ready);

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < P_NUM_IN; k++) begin
            if (int'(w_grant_idx) == k) w_sel_data = i_data[k*P_WIDTH +: P_WIDTH];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (w_in_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_sel   <= w_grant_idx;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sel   = r_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench: a round-robin and a fixed-priority instance run side by side
// against a behavioural model, directed scenarios first, then randomized traffic.
`timescale 1ns/1ps
module tb_rr_arb_mux;
    import pbl3_pkg::*;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // index 0: round-robin instance, index 1: fixed-priority instance
    logic [N-1:0]   dv[2];
    logic [N*W-1:0] dd[2];
    logic           rdy[2];
    logic [N-1:0]   o_rdy[2];
    logic           o_vld[2];
    logic [W-1:0]   o_dat[2];
    logic [SW-1:0]  o_sl[2];

    rr_arb_mux #(.P_WIDTH(W), .P_NUM_IN(N), .P_MODE(ARB_RR)) u_dut_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(dv[0]), .o_ready(o_rdy[0]),
        .i_data(dd[0]), .o_valid(o_vld[0]), .i_ready(rdy[0]),
        .o_data(o_dat[0]), .o_sel(o_sl[0])
    );

    rr_arb_mux #(.P_WIDTH(W), .P_NUM_IN(N), .P_MODE(ARB_FIXED)) u_dut_fx (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(dv[1]), .o_ready(o_rdy[1]),
        .i_data(dd[1]), .o_valid(o_vld[1]), .i_ready(rdy[1]),
        .o_data(o_dat[1]), .o_sel(o_sl[1])
    );

    // reference model state
    bit           m_valid[2];
    logic [W-1:0] m_data[2];
    int           m_sel[2];
    int           m_ptr[2];
    bit           pend[2][N];
    logic [W-1:0] pend_data[2][N];
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic string nm(input int d);
        return (d == 0) ? "rr" : "fx";
    endfunction

    // Grant choice: round-robin scans ptr, ptr+1, ... modulo N; fixed takes the lowest index.
    function automatic int pick(input int d);
        int n;
        int g;
        g = -1;
        for (int i = 0; i < N; i++) begin
            n = (d == 0) ? (m_ptr[d] + i) % N : i;
            if (g < 0 && dv[d][n]) g = n;
        end
        return g;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_sel[d]   = 0;
            m_ptr[d]   = 0;
            for (int k = 0; k < N; k++) pend[d][k] = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // One clock cycle: inputs already applied; checks o_ready, advances the model, checks registers.
    task automatic step();
        int           g;
        bit           can;
        logic [N-1:0] er;
        logic [W-1:0] front;
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
                if (rst_n && pend[d][k])
                    check($sformatf("%s producer_hold ch%0d", nm(d), k),
                          {31'd0, dv[d][k], dd[d][k*W +: W]}, {31'd0, 1'b1, pend_data[d][k]});
            end
            g   = -1;
            can = rst_n && (!m_valid[d] || rdy[d]);
            if (can) g = pick(d);
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            check($sformatf("%s o_ready", nm(d)), 64'(o_rdy[d]), 64'(er));

            if (rst_n && m_valid[d] && rdy[d]) begin
                if (d == 0 && exp_q0.size() > 0) begin
                    front = exp_q0.pop_front();
                    check("rr sb_out", 64'(o_dat[d]), 64'(front));
                end
                if (d == 1 && exp_q1.size() > 0) begin
                    front = exp_q1.pop_front();
                    check("fx sb_out", 64'(o_dat[d]), 64'(front));
                end
            end

            for (int k = 0; k < N; k++) pend[d][k] = 1'b0;
            if (!rst_n) begin
                m_valid[d] = 1'b0;
                m_data[d]  = '0;
                m_sel[d]   = 0;
                m_ptr[d]   = 0;
                if (d == 0) exp_q0.delete(); else exp_q1.delete();
            end else begin
                if (m_valid[d] && rdy[d]) m_valid[d] = 1'b0;
                if (g >= 0) begin
                    m_valid[d] = 1'b1;
                    m_data[d]  = dd[d][g*W +: W];
                    m_sel[d]   = g;
                    if (d == 0) begin
                        exp_q0.push_back(m_data[d]);
                        m_ptr[d] = (g + 1) % N;
                    end else begin
                        exp_q1.push_back(m_data[d]);
                    end
                end
                for (int k = 0; k < N; k++) begin
                    if (dv[d][k] && g != k) begin
                        pend[d][k]      = 1'b1;
                        pend_data[d][k] = dd[d][k*W +: W];
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s o_valid", nm(d)), 64'(o_vld[d]), 64'(m_valid[d]));
            check($sformatf("%s o_data", nm(d)), 64'(o_dat[d]), 64'(m_data[d]));
            check($sformatf("%s o_sel", nm(d)), 64'(o_sl[d]), 64'(m_sel[d]));
        end
    endtask

    // driver tasks
    task automatic set_data(input int d, input logic [W-1:0] base);
        for (int k = 0; k < N; k++) dd[d][k*W +: W] = base + W'(k);
    endtask

    task automatic rand_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[d][k]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        dv[d][k]          = 1'b1;
                        dd[d][k*W +: W]   = $urandom();
                    end else begin
                        dv[d][k] = 1'b0;
                    end
                end
            end
            rdy[d] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic sync_reset_pulse();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            dv[d]  = '0;
            dd[d]  = '0;
            rdy[d] = 1'b0;
        end
        model_reset();

        // reset held with all requests raised
        dv[0] = 4'hF; dv[1] = 4'hF;
        set_data(0, 32'hA0); set_data(1, 32'hA0);
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        repeat (3) step();
        check("t1 o_ready in reset", 64'(o_rdy[0]), 64'h0);
        check("t1 o_valid in reset", 64'(o_vld[0]), 64'h0);
        rst_n = 1'b1;
        step();
        check("t1 first sel", 64'(o_sl[0]), 64'd0);
        check("t1 first data", 64'(o_dat[0]), 64'hA0);

        // round-robin rotation and fixed priority under full load
        for (int i = 1; i <= 5; i++) begin
            step();
            check("t2 rr sel", 64'(o_sl[0]), 64'(i % 4));
            check("t2 rr data", 64'(o_dat[0]), 64'(32'hA0 + i % 4));
            check("t2 rr valid", 64'(o_vld[0]), 64'd1);
            check("t5 fx sel", 64'(o_sl[1]), 64'd0);
        end
        dv[1] = 4'hE;
        repeat (2) begin
            step();
            check("t5 fx sel after drop", 64'(o_sl[1]), 64'd1);
            check("t5 fx data after drop", 64'(o_dat[1]), 64'hA1);
        end

        // stall with a held word, then drain and refill together
        dv[0] = '0; dv[1] = '0;
        sync_reset_pulse();
        dv[0] = 4'b0001; dd[0][0 +: W] = 32'h11; rdy[0] = 1'b0;
        step();
        set_data(0, 32'hA0); dv[0] = 4'hF;
        repeat (3) begin
            step();
            check("t3 stall data", 64'(o_dat[0]), 64'h11);
            check("t3 stall sel", 64'(o_sl[0]), 64'd0);
            check("t3 stall ready", 64'(o_rdy[0]), 64'h0);
        end
        rdy[0] = 1'b1;
        step();
        check("t3 refill sel", 64'(o_sl[0]), 64'd1);
        check("t3 refill data", 64'(o_dat[0]), 64'hA1);

        // pointer wrap search, then drain to empty
        dv[0] = '0;
        sync_reset_pulse();
        dv[0] = 4'b0100; rdy[0] = 1'b1;
        step();
        check("t4 sel ch2", 64'(o_sl[0]), 64'd2);
        dv[0] = 4'b0010;
        step();
        check("t4 wrap sel", 64'(o_sl[0]), 64'd1);
        check("t4 wrap data", 64'(o_dat[0]), 64'hA1);
        dv[0] = '0;
        step();
        check("t4 drained", 64'(o_vld[0]), 64'd0);
        dv[0] = 4'hF;
        step();
        check("t4 ptr after wrap", 64'(o_sl[0]), 64'd2);

        // asynchronous reset between edges while stalled
        dv[0] = '0;
        sync_reset_pulse();
        dv[0] = 4'b0001; rdy[0] = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async o_valid", 64'(o_vld[0]), 64'd0);
        check("t6 async o_ready", 64'(o_rdy[0]), 64'h0);
        check("t6 async o_data", 64'(o_dat[0]), 64'h0);
        model_reset();
        step();
        rst_n = 1'b1;
        dv[0] = 4'hF; rdy[0] = 1'b1;
        step();
        check("t6 post-reset sel", 64'(o_sl[0]), 64'd0);
        check("t6 post-reset data", 64'(o_dat[0]), 64'hA0);

        // randomized traffic on both instances
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
